// File: rtl/oled_pkg.sv
// Shared state encoding, byte-class constants and command tables for the
// SSD1306 frame sequencer.
package oled_pkg;

  localparam int INIT_ROM_LEN = 25;
  localparam int ADDR_LEN     = 6;

  // Value driven on tx_dc: command bytes vs display-data bytes
  localparam logic DC_CMD  = 1'b0;
  localparam logic DC_DATA = 1'b1;

  typedef enum logic [2:0] {
    ST_INIT    = 3'd0,
    ST_IDLE    = 3'd1,
    ST_ADDR    = 3'd2,
    ST_FETCH   = 3'd3,
    ST_WAIT_RD = 3'd4,
    ST_SEND    = 3'd5
  } state_t;

  // Panel power-up sequence: display off, clocking, multiplex, offset, charge
  // pump, horizontal addressing, remap/scan, contrast, precharge, display on.
  localparam logic [7:0] INIT_ROM [INIT_ROM_LEN] = '{
    8'hAE, 8'hD5, 8'h80, 8'hA8, 8'h3F, 8'hD3, 8'h00, 8'h40, 8'h8D, 8'h14,
    8'h20, 8'h00, 8'hA1, 8'hC8, 8'hDA, 8'h12, 8'h81, 8'hCF, 8'hD9, 8'hF1,
    8'hDB, 8'h40, 8'hA4, 8'hA6, 8'hAF
  };

  // Full-screen address window: columns 0..127, pages 0..7
  localparam logic [7:0] ADDR_CMDS [ADDR_LEN] = '{
    8'h21, 8'h00, 8'h7F, 8'h22, 8'h00, 8'h07
  };

endpackage

// File: rtl/frame_tick_gen.sv
// Free-running frame-rate divider: counts 0..FRAME_DIV-1 and raises a
// one-cycle tick while the count sits at its terminal value.
module frame_tick_gen #(
  parameter int FRAME_DIV = 2_700_000
) (
  input  logic clk,
  input  logic rst,
  output logic o_tick
);

  localparam int CW = (FRAME_DIV > 2) ? $clog2(FRAME_DIV) : 1;

  logic [CW-1:0] r_count;

  assign o_tick = (r_count == CW'(FRAME_DIV - 1));

  // Divider counter, wraps to zero on the tick cycle
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignment so every register
    // samples pre-edge values regardless of process evaluation order.
    if (rst) begin
      r_count <= '0;
    end else if (o_tick) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + 1'b1;
    end
  end

endmodule

// File: rtl/oled_frame_sequencer.sv
// Drives full-screen SSD1306 refreshes: init command list once after reset,
// then per frame tick the address window followed by FRAME_BYTES image bytes
// fetched from the image controller and handed to the byte transmitter.
module oled_frame_sequencer
  import oled_pkg::*;
#(
  parameter int FRAME_DIV   = 2_700_000,
  parameter int FRAME_BYTES = 1024,
  parameter int INIT_LEN    = INIT_ROM_LEN
) (
  input  logic       clk,
  input  logic       rst,
  output logic [9:0] byte_counter,
  input  logic [7:0] pixel_data,
  output logic [7:0] tx_data,
  output logic       tx_dc,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic       frame_done,
  output logic       busy
);

  state_t     r_state;
  logic [4:0] r_idx;
  logic       r_pending;
  logic       w_tick;
  logic       w_accept;

  frame_tick_gen #(.FRAME_DIV(FRAME_DIV)) u_tick_gen (
    .clk    (clk),
    .rst    (rst),
    .o_tick (w_tick)
  );

  assign w_accept = tx_valid && tx_ready;

  // Sequencer FSM with registered transmitter-side outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_INIT;
      r_idx        <= '0;
      r_pending    <= 1'b0;
      byte_counter <= '0;
      tx_data      <= '0;
      tx_dc        <= DC_CMD;
      tx_valid     <= 1'b0;
      frame_done   <= 1'b0;
      busy         <= 1'b1;
    end else begin
      frame_done <= 1'b0;

      // A tick that lands while a transfer is running is remembered once;
      // in IDLE the tick is consumed directly by the exit below.
      if (r_state != ST_IDLE && w_tick) begin
        r_pending <= 1'b1;
      end

      case (r_state)
        ST_INIT: begin
          // Payload is loaded only while tx_valid is low, so it stays
          // frozen for as long as the transmitter stalls.
          if (!tx_valid) begin
            tx_data  <= INIT_ROM[r_idx];
            tx_dc    <= DC_CMD;
            tx_valid <= 1'b1;
          end else if (tx_ready) begin
            tx_valid <= 1'b0;
            if (r_idx == 5'(INIT_LEN - 1)) begin
              r_idx   <= '0;
              r_state <= ST_IDLE;
              busy    <= 1'b0;
            end else begin
              r_idx <= r_idx + 1'b1;
            end
          end
        end

        ST_IDLE: begin
          if (r_pending || w_tick) begin
            r_pending <= 1'b0;
            r_idx     <= '0;
            r_state   <= ST_ADDR;
            busy      <= 1'b1;
          end
        end

        ST_ADDR: begin
          if (!tx_valid) begin
            tx_data  <= ADDR_CMDS[r_idx[2:0]];
            tx_dc    <= DC_CMD;
            tx_valid <= 1'b1;
          end else if (tx_ready) begin
            tx_valid <= 1'b0;
            if (r_idx == 5'(ADDR_LEN - 1)) begin
              r_idx        <= '0;
              byte_counter <= '0;
              r_state      <= ST_FETCH;
            end else begin
              r_idx <= r_idx + 1'b1;
            end
          end
        end

        // The image source registers its output, so give it one clock
        // with a stable byte_counter before sampling pixel_data.
        ST_FETCH: begin
          r_state <= ST_WAIT_RD;
        end

        ST_WAIT_RD: begin
          tx_data  <= pixel_data;
          tx_dc    <= DC_DATA;
          tx_valid <= 1'b1;
          r_state  <= ST_SEND;
        end

        ST_SEND: begin
          if (w_accept) begin
            tx_valid <= 1'b0;
            if (byte_counter == 10'(FRAME_BYTES - 1)) begin
              byte_counter <= '0;
              frame_done   <= 1'b1;
              busy         <= 1'b0;
              r_state      <= ST_IDLE;
            end else begin
              byte_counter <= byte_counter + 1'b1;
              r_state      <= ST_FETCH;
            end
          end
        end

        default: begin
          r_idx    <= '0;
          tx_valid <= 1'b0;
          busy     <= 1'b1;
          r_state  <= ST_INIT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_oled_frame_sequencer.sv
// Self-checking bench for oled_frame_sequencer: a stream-level reference
// model (expected byte sequence, tick/pending bookkeeping) is compared
// against the DUT every cycle, plus directed literal checks on the captured
// byte log and on cycle timing.
module tb_oled_frame_sequencer;

  localparam int FRAME_DIV   = 4000;
  localparam int FRAME_BYTES = 1024;
  localparam int INIT_N      = 25;
  localparam int ADDR_N      = 6;
  localparam int FRAME_LEN   = ADDR_N + FRAME_BYTES;

  logic       clk = 1'b0;
  logic       rst;
  logic       tx_ready;
  logic [7:0] pixel_data;
  logic [9:0] byte_counter;
  logic [7:0] tx_data;
  logic       tx_dc;
  logic       tx_valid;
  logic       frame_done;
  logic       busy;

  always #5 clk = ~clk;

  oled_frame_sequencer #(
    .FRAME_DIV   (FRAME_DIV),
    .FRAME_BYTES (FRAME_BYTES)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .byte_counter (byte_counter),
    .pixel_data   (pixel_data),
    .tx_data      (tx_data),
    .tx_dc        (tx_dc),
    .tx_valid     (tx_valid),
    .tx_ready     (tx_ready),
    .frame_done   (frame_done),
    .busy         (busy)
  );

  // Image source: one-clock registered lookup of the requested byte
  always @(posedge clk) pixel_data <= byte_counter[7:0] ^ 8'h5A;

  // ---------------- bookkeeping ----------------
  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  logic [7:0] init_ref [INIT_N] = '{
    8'hAE, 8'hD5, 8'h80, 8'hA8, 8'h3F, 8'hD3, 8'h00, 8'h40, 8'h8D, 8'h14,
    8'h20, 8'h00, 8'hA1, 8'hC8, 8'hDA, 8'h12, 8'h81, 8'hCF, 8'hD9, 8'hF1,
    8'hDB, 8'h40, 8'hA4, 8'hA6, 8'hAF
  };
  logic [7:0] addr_ref [ADDR_N] = '{8'h21, 8'h00, 8'h7F, 8'h22, 8'h00, 8'h07};

  typedef enum {M_INIT, M_IDLE, M_FRAME} mphase_t;

  // Expected {dc, byte} at stream position pos of the given phase
  function automatic logic [8:0] exp_byte(input mphase_t ph, input int pos);
    logic [7:0] k8;
    if (ph == M_INIT) return {1'b0, init_ref[pos]};
    if (pos < ADDR_N) return {1'b0, addr_ref[pos]};
    k8 = 8'((pos - ADDR_N) % 256);
    return {1'b1, k8 ^ 8'h5A};
  endfunction

  // ---------------- reference model + compare ----------------
  mphase_t    m_phase;
  int         m_pos;
  bit         m_pending;
  int         m_cnt;
  bit         m_fd_exp;
  bit         m_after_rst;
  bit         stall_prev;
  logic [8:0] stall_val;
  int         cyc;
  int         last_acc;
  bit         rdy_high;
  int         fd_seen;
  logic [8:0] acc_log [$];

  initial begin : monitor
    bit tick_now;
    bit acc;
    m_phase = M_INIT; m_pos = 0; m_pending = 0; m_cnt = 0; m_fd_exp = 0;
    m_after_rst = 0; stall_prev = 0; stall_val = '0; cyc = 0;
    last_acc = -1; rdy_high = 0; fd_seen = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        m_phase = M_INIT; m_pos = 0; m_pending = 0; m_cnt = 0; m_fd_exp = 0;
        m_after_rst = 1; stall_prev = 0; last_acc = -1; rdy_high = 0;
        continue;
      end

      if (m_after_rst) begin
        check("rst_tx_valid", tx_valid, 0);
        check("rst_byte_counter", byte_counter, 0);
        check("rst_tx_data", {tx_dc, tx_data}, 0);
        m_after_rst = 0;
      end

      check("busy", busy, (m_phase != M_IDLE));
      check("frame_done", frame_done, m_fd_exp);
      if (frame_done) fd_seen++;
      if (m_phase == M_IDLE) begin
        check("idle_tx_valid", tx_valid, 0);
        check("idle_byte_counter", byte_counter, 0);
      end else if (tx_valid) begin
        check("tx_byte", {tx_dc, tx_data}, exp_byte(m_phase, m_pos));
        if (m_phase == M_FRAME && m_pos >= ADDR_N)
          check("data_byte_counter", byte_counter, m_pos - ADDR_N);
      end
      if (stall_prev) check("hold_while_stalled", {tx_valid, tx_dc, tx_data}, {1'b1, stall_val});

      // Advance the model across the coming clock edge
      tick_now   = (m_cnt == FRAME_DIV - 1);
      m_cnt      = (m_cnt + 1) % FRAME_DIV;
      m_fd_exp   = 0;
      acc        = tx_valid && tx_ready;
      stall_prev = tx_valid && !tx_ready;
      stall_val  = {tx_dc, tx_data};
      if (!tx_ready) rdy_high = 0;

      if (m_phase == M_IDLE) begin
        if (m_pending || tick_now) begin
          m_phase = M_FRAME; m_pos = 0; m_pending = 0; last_acc = -1; rdy_high = 1;
        end
      end else begin
        if (tick_now) m_pending = 1;
        if (acc) begin
          acc_log.push_back({tx_dc, tx_data});
          if (m_phase == M_FRAME && m_pos >= ADDR_N) begin
            if (last_acc >= 0 && rdy_high) check("data_spacing", cyc - last_acc, 3);
            last_acc = cyc;
            rdy_high = 1;
          end
          m_pos++;
          if (m_phase == M_INIT && m_pos == INIT_N) begin
            m_phase = M_IDLE;
          end else if (m_phase == M_FRAME && m_pos == FRAME_LEN) begin
            m_phase  = M_IDLE;
            m_fd_exp = 1;
          end
        end
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic wait_frame_done(input int budget, input string name);
    int n;
    n = 0;
    while (1) begin
      @(negedge clk);
      n++;
      if (frame_done) break;
      if (n >= budget) begin
        check({name, "_timeout"}, 1, 0);
        break;
      end
    end
  endtask

  initial begin : stim
    int n;
    rst = 1'b1;
    tx_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // 1: init list in order, then IDLE after exactly 50 edges
    n = 0;
    while (1) begin
      @(negedge clk);
      n++;
      if (!busy || n > 200) break;
    end
    check("init_cycles", n, 51);
    check("init_count", acc_log.size(), 25);
    check("init_first", acc_log[0], {1'b0, 8'hAE});
    check("init_13th", acc_log[12], {1'b0, 8'hA1});
    check("init_last", acc_log[24], {1'b0, 8'hAF});

    // 2: first tick -> window commands + 1024 data bytes, one frame_done
    acc_log.delete();
    fd_seen = 0;
    wait_frame_done(FRAME_DIV + 4000, "frame1");
    @(negedge clk);
    check("frame1_done_count", fd_seen, 1);
    check("frame1_len", acc_log.size(), 1030);
    check("frame1_addr0", acc_log[0], {1'b0, 8'h21});
    check("frame1_addr5", acc_log[5], {1'b0, 8'h07});
    check("frame1_data0", acc_log[6], {1'b1, 8'h5A});
    check("frame1_data1", acc_log[7], {1'b1, 8'h5B});
    check("frame1_data90", acc_log[6 + 90], {1'b1, 8'h00});
    check("frame1_data1023", acc_log[1029], {1'b1, 8'hA5});

    // 6: no pending, next frame starts on the next tick (edge 8000 vs 7084)
    n = 1;
    while (1) begin
      if (busy || n > FRAME_DIV + 10) break;
      @(negedge clk);
      n++;
    end
    check("idle_gap_to_tick", n, 916);

    // 3: random 30% ready duty; model checks stream and hold stability
    acc_log.delete();
    fd_seen = 0;
    n = 0;
    while (fd_seen == 0 && n < 20000) begin
      @(posedge clk);
      #1 tx_ready = ($urandom_range(0, 9) < 3);
      n++;
    end
    check("random_frame_done", fd_seen, 1);
    check("random_frame_len", acc_log.size(), 1030);
    @(posedge clk);
    #1 tx_ready = 1'b1;

    // 4: stall across two ticks mid-frame, then exactly one pending frame
    n = 0;
    while (1) begin
      @(negedge clk);
      n++;
      if ((tx_valid && tx_dc && byte_counter == 10'd100) || n > 12000) break;
    end
    check("stall_point_found", (n <= 12000), 1);
    @(posedge clk);
    #1 tx_ready = 1'b0;
    repeat (2 * FRAME_DIV + 1000) @(posedge clk);
    #1 tx_ready = 1'b1;
    wait_frame_done(4000, "stalled_frame");
    check("stalled_frame_idle", busy, 0);
    @(negedge clk);
    check("pending_restart", busy, 1);

    // 5: reset at data byte 500 abandons the frame and restarts init
    n = 0;
    while (1) begin
      @(negedge clk);
      n++;
      if ((tx_valid && tx_dc && byte_counter == 10'd500) || n > 12000) break;
    end
    check("reset_point_found", (n <= 12000), 1);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    acc_log.delete();
    check("after_rst_valid", tx_valid, 0);
    check("after_rst_byte_counter", byte_counter, 0);
    n = 0;
    while (1) begin
      @(negedge clk);
      n++;
      if (!busy || n > 200) break;
    end
    check("reinit_count", acc_log.size(), 25);
    check("reinit_first", acc_log[0], {1'b0, 8'hAE});
    check("reinit_last", acc_log[24], {1'b0, 8'hAF});

    repeat (20) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin : watchdog
    #900_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
